// File: rtl/cdr_phase_ctrl.sv
// Loop controller for an Alexander phase detector: vote filter, phase stepper, ACQ/LOCK FSM.
// Optional macro CDR_PHASE_HOLD_EN adds i_hold, which freezes voting, stepping and FSM state.
module cdr_phase_ctrl #(
    parameter int unsigned NB_PHASES  = 25,
    parameter int unsigned ACC_W      = 5,
    parameter int unsigned TH_ACQ     = 4,
    parameter int unsigned TH_TRK     = 8,
    parameter int unsigned WIN        = 32,
    parameter int unsigned LOCK_WIN   = 4,
    parameter int unsigned LOSS_STEPS = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic       i_T,
    input  logic       i_E,
    input  logic       i_restart,
`ifdef CDR_PHASE_HOLD_EN
    input  logic       i_hold,
`endif
    output logic [5:0] o_phase,
    output logic       o_step,
    output logic       o_dir,
    output logic       o_lock
);

    localparam int unsigned SUM_W   = ACC_W + 1;
    localparam int unsigned WIN_W   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned QUIET_W = $clog2(LOCK_WIN + 1);
    localparam int unsigned LOSS_W  = $clog2(LOSS_STEPS + 1);

    localparam logic [5:0]         PH_CENTRE  = 6'(NB_PHASES / 2);
    localparam logic [5:0]         PH_LAST    = 6'(NB_PHASES - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN - 1);
    localparam logic [QUIET_W-1:0] QUIET_FULL = QUIET_W'(LOCK_WIN);
    localparam logic [LOSS_W-1:0]  LOSS_FULL  = LOSS_W'(LOSS_STEPS);

    typedef enum logic [0:0] {StAcq, StLock} state_e;

    state_e                  state;
    logic signed [ACC_W-1:0] acc;
    logic [WIN_W-1:0]        win_cnt;
    logic                    win_stepped;
    logic [QUIET_W-1:0]      quiet_cnt;
    logic [LOSS_W-1:0]       loss_cnt;

    logic                    hold;
    logic                    active;
    logic signed [SUM_W-1:0] vote;
    logic signed [SUM_W-1:0] acc_sum;
    logic signed [SUM_W-1:0] th_pos;
    logic signed [SUM_W-1:0] th_neg;
    logic                    step_up;
    logic                    step_dn;
    logic                    step_any;
    logic                    win_wrap;
    logic [5:0]              phase_inc;
    logic [5:0]              phase_dec;
    logic [QUIET_W-1:0]      quiet_nxt;
    logic [LOSS_W-1:0]       loss_nxt;

`ifdef CDR_PHASE_HOLD_EN
    assign hold = i_hold;
`else
    assign hold = 1'b0;
`endif

    assign o_lock = (state == StLock);

    always_comb begin
        active = i_valid & ~hold;
        vote   = '0;
        if (i_T) begin
            vote = i_E ? SUM_W'(1) : '1;
        end
        acc_sum  = {acc[ACC_W-1], acc} + vote;
        th_pos   = (state == StLock) ? SUM_W'(TH_TRK) : SUM_W'(TH_ACQ);
        th_neg   = -th_pos;
        step_up  = active && (acc_sum >= th_pos);
        step_dn  = active && (acc_sum <= th_neg);
        step_any = step_up | step_dn;
        win_wrap = active && (win_cnt == WIN_LAST);

        phase_inc = (o_phase >= PH_LAST) ? 6'd0 : o_phase + 6'd1;
        phase_dec = (o_phase == 6'd0) ? PH_LAST : o_phase - 6'd1;

        // A step on the wrapping strobe belongs to the ending window.
        quiet_nxt = quiet_cnt;
        if (step_any) begin
            quiet_nxt = '0;
        end else if (win_wrap && !win_stepped && (quiet_cnt != QUIET_FULL)) begin
            quiet_nxt = quiet_cnt + QUIET_W'(1);
        end

        // Run length of same-direction steps; a reversal restarts the run at 1.
        loss_nxt = LOSS_W'(1);
        if ((loss_cnt != '0) && (step_up == o_dir) && (loss_cnt != LOSS_FULL)) begin
            loss_nxt = loss_cnt + LOSS_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state       <= StAcq;
            acc         <= '0;
            win_cnt     <= '0;
            win_stepped <= 1'b0;
            quiet_cnt   <= '0;
            loss_cnt    <= '0;
            o_phase     <= PH_CENTRE;
            o_step      <= 1'b0;
            o_dir       <= 1'b0;
        end else begin
            o_step <= 1'b0;
            if (i_restart) begin
                state       <= StAcq;
                acc         <= '0;
                win_cnt     <= '0;
                win_stepped <= 1'b0;
                quiet_cnt   <= '0;
                loss_cnt    <= '0;
            end else if (active) begin
                if (step_up) begin
                    o_phase <= phase_inc;
                    o_dir   <= 1'b1;
                    o_step  <= 1'b1;
                    acc     <= '0;
                end else if (step_dn) begin
                    o_phase <= phase_dec;
                    o_dir   <= 1'b0;
                    o_step  <= 1'b1;
                    acc     <= '0;
                end else begin
                    acc <= acc_sum[ACC_W-1:0];
                end

                win_cnt     <= win_wrap ? '0 : win_cnt + WIN_W'(1);
                win_stepped <= ~win_wrap & (win_stepped | step_any);
                quiet_cnt   <= quiet_nxt;

                unique case (state)
                    StAcq: begin
                        if (quiet_nxt == QUIET_FULL) begin
                            state    <= StLock;
                            acc      <= '0;
                            loss_cnt <= '0;
                        end
                    end
                    StLock: begin
                        if (step_any) begin
                            if (loss_nxt == LOSS_FULL) begin
                                state       <= StAcq;
                                acc         <= '0;
                                win_cnt     <= '0;
                                win_stepped <= 1'b0;
                                quiet_cnt   <= '0;
                                loss_cnt    <= '0;
                            end else begin
                                loss_cnt <= loss_nxt;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cdr_phase_ctrl.sv
// Scoreboard bench for cdr_phase_ctrl: stimulus queues expected outputs, a monitor checks them.
module tb_cdr_phase_ctrl;

    logic       i_clk     = 1'b0;
    logic       i_rst     = 1'b0;
    logic       i_valid   = 1'b0;
    logic       i_T       = 1'b0;
    logic       i_E       = 1'b0;
    logic       i_restart = 1'b0;
`ifdef CDR_PHASE_HOLD_EN
    logic       i_hold    = 1'b0;
`endif
    logic [5:0] o_phase;
    logic       o_step;
    logic       o_dir;
    logic       o_lock;

    typedef struct {
        logic [5:0] ph;
        logic       st;
        logic       dr;
        logic       lk;
        string      nm;
    } exp_t;

    exp_t       sb[$];
    int         n_tests     = 0;
    int         n_fail      = 0;
    logic       chk_pending = 1'b0;
    logic [5:0] exp_ph      = 6'd12;
    logic       exp_dir     = 1'b0;

    cdr_phase_ctrl dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_T      (i_T),
        .i_E      (i_E),
        .i_restart(i_restart),
`ifdef CDR_PHASE_HOLD_EN
        .i_hold   (i_hold),
`endif
        .o_phase  (o_phase),
        .o_step   (o_step),
        .o_dir    (o_dir),
        .o_lock   (o_lock)
    );

    always #5 i_clk = ~i_clk;

    task automatic expect_push(input logic [5:0] ph, input logic st, input logic dr,
                               input logic lk, input string nm);
        exp_t e;
        e.ph = ph;
        e.st = st;
        e.dr = dr;
        e.lk = lk;
        e.nm = nm;
        sb.push_back(e);
    endtask

    // One input cycle followed by one idle cycle; exp_ph/exp_dir already hold the outcome.
    task automatic drive(input logic v, input logic t, input logic e, input logic rs,
                         input logic st, input logic lk, input string nm);
        @(negedge i_clk);
        i_valid   = v;
        i_T       = t;
        i_E       = e;
        i_restart = rs;
        expect_push(exp_ph, st, exp_dir, lk, nm);
        @(negedge i_clk);
        i_valid   = 1'b0;
        i_T       = 1'b0;
        i_E       = 1'b0;
        i_restart = 1'b0;
    endtask

    // n_steps groups of th identical votes; the last vote of each group steps (25 phases).
    task automatic vote_steps(input logic up, input int n_steps, input int th, input logic lk,
                              input logic lk_last, input string nm);
        for (int s = 0; s < n_steps; s++) begin
            for (int k = 1; k <= th; k++) begin
                if (k < th) begin
                    drive(1'b1, 1'b1, up, 1'b0, 1'b0, lk, nm);
                end else begin
                    if (up) exp_ph = (exp_ph == 6'd24) ? 6'd0 : exp_ph + 6'd1;
                    else    exp_ph = (exp_ph == 6'd0) ? 6'd24 : exp_ph - 6'd1;
                    exp_dir = up;
                    drive(1'b1, 1'b1, up, 1'b0, 1'b1, (s == n_steps - 1) ? lk_last : lk, nm);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge i_clk);
        chk_pending = !i_rst || i_valid || i_restart;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (chk_pending) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL no_expect: got phase=%0d step=%b with nothing queued",
                             o_phase, o_step);
                end else begin
                    e = sb.pop_front();
                    if (o_phase !== e.ph || o_step !== e.st || o_dir !== e.dr || o_lock !== e.lk)
                    begin
                        n_fail++;
                        $display("FAIL %s: got phase=%0d step=%b dir=%b lock=%b, expected phase=%0d step=%b dir=%b lock=%b",
                                 e.nm, o_phase, o_step, o_dir, o_lock, e.ph, e.st, e.dr, e.lk);
                    end
                end
            end else if (i_rst === 1'b1) begin
                n_tests++;
                if (o_step !== 1'b0) begin
                    n_fail++;
                    $display("FAIL step_idle: got step=%b, expected 0", o_step);
                end
            end
        end
    end

    initial begin : stim
        expect_push(6'd12, 1'b0, 1'b0, 1'b0, "reset");
        expect_push(6'd12, 1'b0, 1'b0, 1'b0, "reset");
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;

        vote_steps(1'b1, 1, 4, 1'b0, 1'b0, "acq_up");       // 12 -> 13
        vote_steps(1'b0, 13, 4, 1'b0, 1'b0, "acq_dn");      // 13 -> 0
        vote_steps(1'b0, 1, 4, 1'b0, 1'b0, "wrap_dn");      // 0 -> 24
        vote_steps(1'b1, 1, 4, 1'b0, 1'b0, "wrap_up");      // 24 -> 0

        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "restart_idle");
        for (int i = 0; i < 128; i++) begin
            drive(1'b1, 1'b1, (i % 2 == 0), 1'b0, 1'b0, (i == 127), "acq_to_lock");
        end

        vote_steps(1'b1, 1, 8, 1'b1, 1'b1, "trk_up");       // 0 -> 1
        vote_steps(1'b1, 1, 8, 1'b1, 1'b1, "keep_a");       // 2
        vote_steps(1'b0, 1, 8, 1'b1, 1'b1, "keep_b");       // 1
        vote_steps(1'b1, 1, 8, 1'b1, 1'b1, "keep_c");       // 2
        vote_steps(1'b1, 1, 8, 1'b1, 1'b1, "keep_d");       // 3
        vote_steps(1'b0, 1, 8, 1'b1, 1'b1, "keep_e");       // 2
        vote_steps(1'b1, 3, 8, 1'b1, 1'b0, "loss");         // 5, lock drops on 3rd step

        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "restart_acq");
        for (int i = 0; i < 128; i++) begin
            drive(1'b1, 1'b1, (i % 2 == 0), 1'b0, 1'b0, (i == 127), "relock");
        end
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "pre_restart");
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "restart_ovr");
        vote_steps(1'b1, 1, 4, 1'b0, 1'b0, "post_restart"); // 5 -> 6

`ifdef CDR_PHASE_HOLD_EN
        i_hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "hold");
        end
        i_hold = 1'b0;
        vote_steps(1'b1, 1, 4, 1'b0, 1'b0, "hold_release");
`endif

        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "pre_rst");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "pre_rst");
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_valid = 1'b1;
        i_T     = 1'b1;
        i_E     = 1'b1;
        exp_ph  = 6'd12;
        exp_dir = 1'b0;
        expect_push(6'd12, 1'b0, 1'b0, 1'b0, "rst_mid");
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_T     = 1'b0;
        i_E     = 1'b0;
        vote_steps(1'b1, 1, 4, 1'b0, 1'b0, "post_rst");     // 12 -> 13

        repeat (4) @(negedge i_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
